// File: rtl/calc_pkg.sv
// Shared calculator types: raw keypad vector, decoded key code, and the encoder.
// Purely combinational helpers; no state lives here.
// Consumers import this package to agree on key encoding.
package calc_pkg;

  // One bit per physical key; the first field is the MSB.
  typedef struct packed {
    logic on;
    logic clear;
    logic mem_rc;
    logic mem_add;
    logic mem_sub;
    logic op_add;
    logic op_sub;
    logic op_mul;
    logic op_div;
    logic equals;
    logic dot;
    logic sign;
    logic percent;
    logic num_0;
    logic num_1;
    logic num_2;
    logic num_3;
    logic num_4;
    logic num_5;
    logic num_6;
    logic num_7;
    logic num_8;
    logic num_9;
  } buttons_t;

  typedef enum logic [4:0] {
    B_NONE,
    B_ON, B_CLEAR, B_MEM_RC, B_MEM_ADD, B_MEM_SUB,
    B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV,
    B_EQUALS, B_DOT, B_SIGN, B_PERCENT,
    B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
    B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
    B_UNKNOWN
  } active_button_t;

  // Zero keys -> B_NONE, several keys at once -> B_UNKNOWN, else the key by name.
  function automatic active_button_t buttonsToActive(input buttons_t b);
    logic [22:0]    v;
    logic [4:0]     n;
    active_button_t r;
    v = b;
    n = '0;
    for (int i = 0; i < 23; i++) n = n + 5'(v[i]);
    r = B_NONE;
    if (n > 5'd1)         r = B_UNKNOWN;
    else if (b.on)        r = B_ON;
    else if (b.clear)     r = B_CLEAR;
    else if (b.mem_rc)    r = B_MEM_RC;
    else if (b.mem_add)   r = B_MEM_ADD;
    else if (b.mem_sub)   r = B_MEM_SUB;
    else if (b.op_add)    r = B_OP_ADD;
    else if (b.op_sub)    r = B_OP_SUB;
    else if (b.op_mul)    r = B_OP_MUL;
    else if (b.op_div)    r = B_OP_DIV;
    else if (b.equals)    r = B_EQUALS;
    else if (b.dot)       r = B_DOT;
    else if (b.sign)      r = B_SIGN;
    else if (b.percent)   r = B_PERCENT;
    else if (b.num_0)     r = B_NUM_0;
    else if (b.num_1)     r = B_NUM_1;
    else if (b.num_2)     r = B_NUM_2;
    else if (b.num_3)     r = B_NUM_3;
    else if (b.num_4)     r = B_NUM_4;
    else if (b.num_5)     r = B_NUM_5;
    else if (b.num_6)     r = B_NUM_6;
    else if (b.num_7)     r = B_NUM_7;
    else if (b.num_8)     r = B_NUM_8;
    else if (b.num_9)     r = B_NUM_9;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous level inputs.
// Latency: 2 clk edges from d_i to q_o.
// No backpressure; samples every cycle.
module sync_2ff #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_d, s1_q;
  logic [Width-1:0] s2_d, s2_q;

  // Shift chain: raw input -> stage 1 -> stage 2.
  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  // Both stages clear on reset so the decoder sees an idle keypad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_decoder.sv
// Debounces the keypad and emits one decoded key event per press.
// Latency: event visible DebounceCycles+3 edges after a clean press reaches the synchronizer.
// Backpressure: event held on valid_o/button_o until ready_i; keypad ignored meanwhile.
module button_decoder
  import calc_pkg::*;
#(
  parameter int DebounceCycles = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  buttons_t       buttons_i,
  output active_button_t button_o,
  output logic           valid_o,
  input  logic           ready_i
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

  buttons_t       sample;
  state_t         state_d, state_q;
  buttons_t       cap_d, cap_q;
  active_button_t code_d, code_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic           valid_d, valid_q;
  active_button_t button_d, button_q;

  sync_2ff #(.Width($bits(buttons_t))) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (buttons_i),
    .q_o (sample)
  );

  // Next-state logic; the counter never passes CntMax, so it cannot wrap.
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    button_d = button_q;
    case (state_q)
      IDLE: begin
        if (sample != '0) begin
          cap_d   = sample;
          code_d  = buttonsToActive(sample);
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sample != cap_q) begin
          state_d = IDLE;
        end else if (cnt_q == CntMax) begin
          state_d  = EMIT;
          valid_d  = 1'b1;
          button_d = code_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (valid_q && ready_i) begin
          state_d  = RELEASE;
          cnt_d    = '0;
          valid_d  = 1'b0;
          button_d = B_NONE;
        end
      end
      RELEASE: begin
        if (sample != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops valid_o without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      code_q   <= B_NONE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      button_q <= B_NONE;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      button_q <= button_d;
    end
  end

  assign valid_o  = valid_q;
  assign button_o = button_q;

endmodule

// File: tb/tb_button_decoder.sv
// Directed bench for button_decoder with DebounceCycles=4.
// Inputs change 1ns after posedge; outputs checked at negedge or mid-cycle.
// Handshakes are counted by a negedge monitor.
module tb_button_decoder;
  import calc_pkg::*;

  logic           clk;
  logic           rst;
  buttons_t       buttons_i;
  active_button_t button_o;
  logic           valid_o;
  logic           ready_i;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  active_button_t last_btn = B_NONE;
  int ev0;
  buttons_t b;

  button_decoder #(.DebounceCycles(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons_i (buttons_i),
    .button_o  (button_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event (handshake completes at the following posedge).
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      ev_cnt++;
      last_btn = button_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    buttons_i = '0;
    ready_i = 1'b1;
    cyc(3);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_button", 32'(button_o), 32'(B_NONE));
    rst = 1'b0;
    cyc(2);

    // Clean num_7 press: valid rises after edge 7, one cycle wide.
    ev0 = ev_cnt;
    b = '0; b.num_7 = 1'b1; buttons_i = b;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) check("n7_valid_e6", 32'(valid_o), 32'd0);
      if (k == 7) begin
        check("n7_valid_e7", 32'(valid_o), 32'd1);
        check("n7_button_e7", 32'(button_o), 32'(B_NUM_7));
      end
      if (k == 8) check("n7_valid_e8", 32'(valid_o), 32'd0);
    end
    cyc(11);
    buttons_i = '0;
    cyc(10);
    check("n7_events", 32'(ev_cnt - ev0), 32'd1);
    check("n7_last", 32'(last_btn), 32'(B_NUM_7));

    // Bouncing op_add never debounces.
    ev0 = ev_cnt;
    b = '0; b.op_add = 1'b1;
    buttons_i = b;  cyc(2);
    buttons_i = '0; cyc(1);
    buttons_i = b;  cyc(2);
    buttons_i = '0; cyc(15);
    check("bounce_events", 32'(ev_cnt - ev0), 32'd0);

    // Two keys together give B_UNKNOWN.
    ev0 = ev_cnt;
    b = '0; b.op_mul = 1'b1; b.num_3 = 1'b1; buttons_i = b;
    cyc(10);
    buttons_i = '0;
    cyc(12);
    check("multi_events", 32'(ev_cnt - ev0), 32'd1);
    check("multi_last", 32'(last_btn), 32'(B_UNKNOWN));

    // Backpressure on dot: output held stable until ready_i.
    ev0 = ev_cnt;
    ready_i = 1'b0;
    b = '0; b.dot = 1'b1; buttons_i = b;
    cyc(8);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("dot_hold_valid", 32'(valid_o), 32'd1);
      check("dot_hold_button", 32'(button_o), 32'(B_DOT));
      if (k == 2) buttons_i = '0;
      if (k == 4) buttons_i = b;
    end
    check("dot_no_early", 32'(ev_cnt - ev0), 32'd0);
    cyc(1);
    ready_i = 1'b1;
    cyc(1);
    check("dot_events", 32'(ev_cnt - ev0), 32'd1);
    check("dot_last", 32'(last_btn), 32'(B_DOT));
    check("dot_valid_drop", 32'(valid_o), 32'd0);
    buttons_i = '0;
    cyc(10);
    check("dot_once", 32'(ev_cnt - ev0), 32'd1);

    // num_2 pressed during release debounce is swallowed; a clean press is not.
    ev0 = ev_cnt;
    b = '0; b.num_1 = 1'b1; buttons_i = b;
    cyc(9);
    buttons_i = '0; cyc(2);
    b = '0; b.num_2 = 1'b1; buttons_i = b;
    cyc(4);
    buttons_i = '0;
    cyc(12);
    check("rel_events", 32'(ev_cnt - ev0), 32'd1);
    check("rel_last", 32'(last_btn), 32'(B_NUM_1));
    buttons_i = b;
    cyc(10);
    buttons_i = '0;
    cyc(10);
    check("n2_events", 32'(ev_cnt - ev0), 32'd2);
    check("n2_last", 32'(last_btn), 32'(B_NUM_2));

    // Reset during EMIT clears outputs asynchronously; held key re-emitted once.
    ev0 = ev_cnt;
    ready_i = 1'b0;
    b = '0; b.num_5 = 1'b1; buttons_i = b;
    cyc(9);
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid_o), 32'd0);
    check("async_rst_button", 32'(button_o), 32'(B_NONE));
    cyc(2);
    rst = 1'b0;
    cyc(9);
    check("post_rst_valid", 32'(valid_o), 32'd1);
    check("post_rst_button", 32'(button_o), 32'(B_NUM_5));
    ready_i = 1'b1;
    cyc(1);
    buttons_i = '0;
    cyc(10);
    check("post_rst_events", 32'(ev_cnt - ev0), 32'd1);
    check("post_rst_last", 32'(last_btn), 32'(B_NUM_5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_decoder.md
BUTTON_DECODER -- requirements
Module: button_decoder

Interface
REQ-001 Parameter DebounceCycles, default 4, is the number of consecutive stable sampled cycles required to accept a press or a release (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 buttons_i  input  calc_pkg::buttons_t (23)  raw, asynchronous, active-high key levels.
REQ-005 button_o  output  calc_pkg::active_button_t (5)  decoded key; it is B_NONE whenever valid_o=0.
REQ-006 valid_o  output  1  button_o holds one accepted key event.
REQ-007 ready_i  input  1  the consumer (calculator core) accepts the event on any cycle where valid_o=1 and ready_i=1.

Function
REQ-008 buttons_i SHALL pass through a 2-flop synchronizer; all decisions use the second-stage vector ("sample").
REQ-009 Encoding SHALL map each field by name to its enum, e.g. on->B_ON, mem_rc->B_MEM_RC, dot->B_DOT, num_0->B_NUM_0.
REQ-010 A sample with more than one bit set SHALL encode as B_UNKNOWN; an all-zero sample SHALL encode as B_NONE.
REQ-011 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, EMIT and RELEASE.
REQ-012 IDLE: when the sample is non-zero, the FSM SHALL capture the sample and its code, clear the counter, and go to DEBOUNCE.
REQ-013 DEBOUNCE: while the sample equals the captured vector, the counter SHALL increment; when it reaches DebounceCycles the FSM SHALL go to EMIT.
REQ-014 DEBOUNCE: any sample differing from the captured vector, including all-zero, SHALL return the FSM to IDLE with no event.
REQ-015 EMIT: valid_o=1 and button_o=captured code; both SHALL be held stable until the handshake completes.
REQ-016 EMIT: on valid_o && ready_i the FSM SHALL go to RELEASE and clear the counter; changes on buttons_i during EMIT SHALL be ignored.
REQ-017 RELEASE: consecutive all-zero samples SHALL increment the counter; any non-zero sample SHALL clear it.
REQ-018 RELEASE: when the counter reaches DebounceCycles the FSM SHALL go to IDLE, so each press yields exactly one event and auto-repeat is not supported.
REQ-019 Latency: with ready_i=1 and a clean press first visible to the synchronizer at edge 0, valid_o SHALL rise after edge DebounceCycles+3 and stay high for exactly one cycle.
REQ-020 The counter SHALL be $clog2(DebounceCycles+1) bits wide and SHALL saturate, never wrapping.
REQ-021 A B_UNKNOWN code that is stable through debounce SHALL be emitted like any other code; filtering it is the consumer's job.

Reset
REQ-022 rst SHALL asynchronously set: the FSM to IDLE, the synchronizer flops and captured vector to 0, the counter to 0, valid_o=0 and button_o=B_NONE.
REQ-023 Reset asserted mid-EMIT SHALL drop valid_o immediately, without waiting for a clock edge, and the pending event SHALL be lost.
REQ-024 After reset release with a key already held, that key SHALL be debounced and emitted once.

Structure
REQ-025 buttons_t, active_button_t and the new button-to-code function buttonsToActive (including its B_UNKNOWN rule) SHALL live in calc_pkg; the FSM state enum SHALL stay local to the module.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff, parameterized by width.
REQ-027 The design SHALL contain no latches, no combinational path from buttons_i to any output, and no dependence of valid_o on ready_i within the same cycle.

Verification (DebounceCycles=4)
REQ-028 Hold num_7 for 20 cycles with ready_i=1 -> exactly one pulse of valid_o with button_o=B_NUM_7, rising after edge 7.
REQ-029 Toggle op_add as 2 cycles high, 1 low, 2 high, then release -> no event is produced.
REQ-030 Hold op_mul and num_3 together for 10 cycles -> one event with button_o=B_UNKNOWN.
REQ-031 Press dot with ready_i=0 for 6 cycles, then raise ready_i -> valid_o and B_DOT are held stable, then consumed exactly once.
REQ-032 Press num_1, then press num_2 before the release debounce completes -> only B_NUM_1 is produced; a later clean num_2 press produces B_NUM_2.
REQ-033 Assert rst while valid_o=1 -> valid_o=0 and button_o=B_NONE asynchronously; a key still held after rst release is re-emitted once.
